pipeline_run_controller: RTL and testbench
==========================================

Name: pipeline_run_controller

Overview:
Sequences the MIPS pipeline between program load, continuous run, single-step and halt. Assembles a UART byte stream into instruction-memory writes and gates pipeline advance with o_run_en. Detects the HALT opcode at fetch, drains the pipeline and reports completion. It sits between the UART/debugger front end and the IF stage and instruction-memory write port.

Parameters:
SIZE, 32, instruction/data word width
MEM_SIZE, 64, instruction memory depth in words
ADDR_WIDTH, $clog2(MEM_SIZE), instruction write address width
DRAIN_CYCLES, 4, cycles to advance after HALT is fetched (IF→WB flush)
HALT_OPCODE, 6'b111111, opcode field value [31:26] marking end of program

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, asynchronous, active-low
i_cmd_valid  in  1  command strobe
i_cmd  in  2  00 LOAD, 01 RUN, 10 STEP, 11 ABORT
o_cmd_ready  out  1  high in IDLE (ABORT is accepted regardless)
i_byte_valid  in  1  program byte strobe
i_byte  in  8  program byte, MSB-first per word
i_if_instruction  in  SIZE  instruction currently fetched by IF
o_run_en  out  1  pipeline advance enable (feeds stall/clock gating)
o_inst_write_enable  out  1  instruction memory write strobe
o_write_addr  out  ADDR_WIDTH  instruction memory write address
o_write_data  out  SIZE  instruction memory write data
o_busy  out  1  state != IDLE
o_halted  out  1  program reached HALT and drained; cleared by LOAD
o_done  out  1  one-cycle pulse at end of LOAD or end of DRAIN
o_state  out  3  current state encoding (debug readback)
o_cycle_count  out  32  cycles with o_run_en high since last LOAD, saturating

Behaviour:
- Reset (i_rst low, async): state IDLE. All outputs 0 except o_cmd_ready=1. Counters, byte index and address cleared.
- States: IDLE=0, LOAD=1, RUN=2, STEP=3, DRAIN=4, DONE=5. All outputs are registered.
- A command is accepted at edge T when i_cmd_valid && (o_cmd_ready || i_cmd==ABORT). The new state is visible at T+1.
- IDLE:
  - LOAD → LOAD. Clears the address, byte index, o_halted and o_cycle_count.
  - RUN → RUN and STEP → STEP, but only if !o_halted. Otherwise the command is consumed with no state change.
- LOAD:
  - Each i_byte_valid shifts i_byte into the word (first byte lands in [31:24]).
  - The 4th byte sets o_write_data and o_write_addr and asserts o_inst_write_enable for exactly 1 cycle on the next cycle. The address then increments.
  - The load ends after writing a word whose [31:26]==HALT_OPCODE, or after writing address MEM_SIZE-1. The address never wraps.
  - On that same cycle o_done pulses, then → IDLE.
  - Bytes outside LOAD are ignored.
- RUN: o_run_en=1 every cycle. When o_run_en && i_if_instruction[31:26]==HALT_OPCODE → DRAIN, with the drain counter loaded to DRAIN_CYCLES.
- STEP: o_run_en=1 for exactly 1 cycle, then → IDLE. If HALT is fetched in that cycle → DRAIN instead.
- DRAIN: o_run_en=1. The counter decrements each cycle; when it reaches 1 → DONE. DRAIN therefore lasts exactly DRAIN_CYCLES cycles.
- DONE (1 cycle): o_run_en=0, o_done=1, o_halted set; → IDLE.
- ABORT in any state → IDLE next cycle:
  - o_run_en drops at that edge.
  - A partial word is discarded and no write is issued.
  - o_halted is unchanged.
  - ABORT coincident with a 4th byte: ABORT wins and there is no write.
- o_cycle_count increments on every cycle with o_run_en=1 and saturates at 32'hFFFFFFFF.
- An accepted command and i_byte_valid in the same cycle while in IDLE: the byte is ignored.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state encodings
  - command codes (CMD_LOAD/RUN/STEP/ABORT)
  - HALT_OPCODE
  - the opcode field slice constants [31:26]
- One sub-module, word_assembler, handles the byte→word shift register, 2-bit byte index, word-valid pulse and synchronous clear (used by LOAD and ABORT).

Test Plan:
- Reset low mid-RUN → next sample shows o_run_en=0, o_state=0, o_cmd_ready=1, o_cycle_count=0.
- LOAD, then bytes 20,08,00,05, FC,00,00,00 → write addr0=32'h20080005, then addr1=32'hFC000000. o_done pulses with the second write and the state returns to IDLE.
- LOAD of 64 words with no HALT → the last write is at addr 63, then o_done and IDLE. There is no write at addr 0 afterwards.
- RUN with i_if_instruction=HALT at run cycle 10 → o_run_en high for 10+4 cycles, then DONE. o_done pulses, o_halted=1 and o_cycle_count=14.
- STEP ×3 from IDLE → three isolated 1-cycle o_run_en pulses, o_cycle_count=3. RUN issued after o_halted=1 is ignored and o_run_en stays 0.
- LOAD, then 3 bytes, then ABORT in the same cycle as the 4th byte → no o_inst_write_enable, IDLE. A new LOAD starts cleanly at addr 0 with byte index 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state, command and opcode-field definitions for the run controller
package mips_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_STEP  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;
  localparam logic [1:0] CMD_LOAD  = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;
  localparam logic [5:0] HALT_OPCODE = 6'b111111;
  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
endpackage

// File: rtl/word_assembler.sv
// word_assembler: shifts program bytes MSB-first into a word and flags the completing byte
module word_assembler #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic [7:0]      data,
  output logic [SIZE-1:0] word,
  output logic            word_valid
);
  logic [SIZE-9:0] sr;
  logic [1:0]      idx;
  // word is combinational so the owner can register it on the completing edge
  assign word       = {sr, data};
  assign word_valid = en && !clr && idx == 2'd3;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr  <= '0;
      idx <= '0;
    end else if (clr) begin
      sr  <= '0;
      idx <= '0;
    end else if (en) begin
      sr  <= word[SIZE-9:0];
      idx <= idx + 2'd1;
    end
endmodule

// File: rtl/pipeline_run_controller.sv
// pipeline_run_controller: sequences program load, run, single-step, halt drain and abort
module pipeline_run_controller
  import mips_ctrl_pkg::*;
#(
  parameter int SIZE         = 32,
  parameter int MEM_SIZE     = 64,
  parameter int ADDR_WIDTH   = $clog2(MEM_SIZE),
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_valid,
  input  logic [1:0]            i_cmd,
  output logic                  o_cmd_ready,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte,
  input  logic [SIZE-1:0]       i_if_instruction,
  output logic                  o_run_en,
  output logic                  o_inst_write_enable,
  output logic [ADDR_WIDTH-1:0] o_write_addr,
  output logic [SIZE-1:0]       o_write_data,
  output logic                  o_busy,
  output logic                  o_halted,
  output logic                  o_done,
  output logic [2:0]            o_state,
  output logic [31:0]           o_cycle_count
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  state_t                state, nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DW-1:0]         drain;
  logic [SIZE-1:0]       word;
  logic                  wv, accept, abort, load_cmd, halt_fetch, last;
  assign accept     = i_cmd_valid && (o_cmd_ready || i_cmd == CMD_ABORT);
  assign abort      = accept && i_cmd == CMD_ABORT;
  assign load_cmd   = accept && i_cmd == CMD_LOAD;
  assign halt_fetch = o_run_en && i_if_instruction[OP_HI:OP_LO] == HALT_OPCODE;
  assign last       = word[OP_HI:OP_LO] == HALT_OPCODE || addr == ADDR_WIDTH'(MEM_SIZE - 1);
  assign o_state    = state;
  // ABORT clears the assembler in the same edge, which also suppresses a coincident 4th byte
  word_assembler #(.SIZE(SIZE)) u_asm (
    .clk       (i_clk),
    .rst_n     (i_rst),
    .clr       (load_cmd || abort),
    .en        (i_byte_valid && state == S_LOAD),
    .data      (i_byte),
    .word      (word),
    .word_valid(wv)
  );
  always_comb begin
    nxt = state;
    if (abort) nxt = S_IDLE;
    else
      case (state)
        S_IDLE:  if (accept) nxt = i_cmd == CMD_LOAD ? S_LOAD : o_halted ? S_IDLE :
                                   i_cmd == CMD_RUN ? S_RUN : S_STEP;
        S_LOAD:  if (wv && last) nxt = S_IDLE;
        S_RUN:   if (halt_fetch) nxt = S_DRAIN;
        S_STEP:  nxt = halt_fetch ? S_DRAIN : S_IDLE;
        S_DRAIN: if (drain == DW'(1)) nxt = S_DONE;
        S_DONE:  nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
  end
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      state               <= S_IDLE;
      addr                <= '0;
      drain               <= '0;
      o_cmd_ready         <= 1'b1;
      o_run_en            <= 1'b0;
      o_busy              <= 1'b0;
      o_halted            <= 1'b0;
      o_done              <= 1'b0;
      o_inst_write_enable <= 1'b0;
      o_write_addr        <= '0;
      o_write_data        <= '0;
      o_cycle_count       <= '0;
    end else begin
      state               <= nxt;
      o_cmd_ready         <= nxt == S_IDLE;
      o_busy              <= nxt != S_IDLE;
      o_run_en            <= nxt inside {S_RUN, S_STEP, S_DRAIN};
      o_done              <= nxt == S_DONE || (wv && last);
      o_inst_write_enable <= wv;
      if (wv) begin
        o_write_addr <= addr;
        o_write_data <= word;
      end
      if (nxt == S_DRAIN && state != S_DRAIN) drain <= DW'(DRAIN_CYCLES);
      else if (state == S_DRAIN) drain <= drain - 1'b1;
      if (load_cmd) begin
        addr          <= '0;
        o_halted      <= 1'b0;
        o_cycle_count <= '0;
      end else begin
        if (wv && !last) addr <= addr + 1'b1;
        if (nxt == S_DONE) o_halted <= 1'b1;
        if (o_run_en && o_cycle_count != '1) o_cycle_count <= o_cycle_count + 32'd1;
      end
    end
endmodule

// File: tb/tb_pipeline_run_controller.sv
// tb_pipeline_run_controller: directed sequence with a write scoreboard for the run controller
module tb_pipeline_run_controller;
  import mips_ctrl_pkg::*;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_cmd_valid, i_byte_valid;
  logic [1:0]  i_cmd;
  logic [7:0]  i_byte;
  logic [31:0] i_if_instruction;
  logic        o_cmd_ready, o_run_en, o_inst_write_enable, o_busy, o_halted, o_done;
  logic [5:0]  o_write_addr;
  logic [31:0] o_write_data, o_cycle_count;
  logic [2:0]  o_state;
  int          tests = 0, fails = 0;
  logic [37:0] sb[$];
  logic [37:0] exp_w;

  always #5 clk = ~clk;

  pipeline_run_controller dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .o_cmd_ready(o_cmd_ready), .i_byte_valid(i_byte_valid), .i_byte(i_byte),
    .i_if_instruction(i_if_instruction), .o_run_en(o_run_en),
    .o_inst_write_enable(o_inst_write_enable), .o_write_addr(o_write_addr),
    .o_write_data(o_write_data), .o_busy(o_busy), .o_halted(o_halted),
    .o_done(o_done), .o_state(o_state), .o_cycle_count(o_cycle_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] c);
    i_cmd_valid = 1'b1;
    i_cmd = c;
    step();
    i_cmd_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    i_byte_valid = 1'b1;
    i_byte = b;
    step();
    i_byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [5:0] a, input logic [31:0] w);
    sb.push_back({a, w});
    for (int k = 0; k < 4; k++) send(w[31-8*k -: 8]);
  endtask

  // every write strobe must match the oldest expected write
  always @(negedge clk)
    if (o_inst_write_enable) begin
      if (sb.size() == 0) check("spurious_write", 32'(o_inst_write_enable), 32'd0);
      else begin
        exp_w = sb.pop_front();
        check("write_addr", 32'(o_write_addr), 32'(exp_w[37:32]));
        check("write_data", o_write_data, exp_w[31:0]);
      end
    end

  initial begin
    int n;
    rst = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd = 2'b00;
    i_byte_valid = 1'b0;
    i_byte = 8'h00;
    i_if_instruction = 32'h0;
    repeat (2) step();
    check("rst_run_en", 32'(o_run_en), 32'd0);
    check("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_halted", 32'(o_halted), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_we", 32'(o_inst_write_enable), 32'd0);
    rst = 1'b1;
    step();
    // reset asserted in the middle of RUN
    cmd(CMD_RUN);
    check("run_state", 32'(o_state), 32'd2);
    check("run_en", 32'(o_run_en), 32'd1);
    repeat (3) step();
    check("run_count3", o_cycle_count, 32'd3);
    rst = 1'b0;
    #1;
    check("midrun_rst_run_en", 32'(o_run_en), 32'd0);
    check("midrun_rst_state", 32'(o_state), 32'd0);
    check("midrun_rst_ready", 32'(o_cmd_ready), 32'd1);
    check("midrun_rst_count", o_cycle_count, 32'd0);
    #2;
    rst = 1'b1;
    step();
    // two-word load ending on HALT
    cmd(CMD_LOAD);
    check("load_state", 32'(o_state), 32'd1);
    check("load_ready", 32'(o_cmd_ready), 32'd0);
    check("load_busy", 32'(o_busy), 32'd1);
    send_word(6'd0, 32'h20080005);
    check("w0_we", 32'(o_inst_write_enable), 32'd1);
    check("w0_no_done", 32'(o_done), 32'd0);
    send_word(6'd1, 32'hFC000000);
    check("w1_we", 32'(o_inst_write_enable), 32'd1);
    check("w1_done", 32'(o_done), 32'd1);
    check("w1_idle", 32'(o_state), 32'd0);
    step();
    check("done_pulse_end", 32'(o_done), 32'd0);
    check("we_pulse_end", 32'(o_inst_write_enable), 32'd0);
    // three single steps
    for (int s = 0; s < 3; s++) begin
      cmd(CMD_STEP);
      check("step_state", 32'(o_state), 32'd3);
      check("step_run_en", 32'(o_run_en), 32'd1);
      step();
      check("step_after_state", 32'(o_state), 32'd0);
      check("step_after_run_en", 32'(o_run_en), 32'd0);
    end
    check("step_count", o_cycle_count, 32'd3);
    // run until HALT fetched at run cycle 10, then drain
    cmd(CMD_LOAD);
    send_word(6'd0, 32'hFC000000);
    check("halt_load_done", 32'(o_done), 32'd1);
    step();
    cmd(CMD_RUN);
    repeat (9) step();
    i_if_instruction = 32'hFC000000;
    step();
    i_if_instruction = 32'h0;
    check("drain_state", 32'(o_state), 32'd4);
    n = 10;
    for (int i = 0; i < 20 && !o_done; i++) begin
      if (o_run_en) n++;
      step();
    end
    check("drain_reached_done", 32'(o_done), 32'd1);
    check("run_en_cycles", 32'(n), 32'd14);
    check("done_state", 32'(o_state), 32'd5);
    check("done_run_en", 32'(o_run_en), 32'd0);
    check("done_halted", 32'(o_halted), 32'd1);
    check("done_count", o_cycle_count, 32'd14);
    step();
    check("post_done_state", 32'(o_state), 32'd0);
    check("post_done_pulse", 32'(o_done), 32'd0);
    check("post_done_halted", 32'(o_halted), 32'd1);
    cmd(CMD_RUN);
    check("halted_run_state", 32'(o_state), 32'd0);
    check("halted_run_en", 32'(o_run_en), 32'd0);
    step();
    check("halted_run_en2", 32'(o_run_en), 32'd0);
    check("halted_count", o_cycle_count, 32'd14);
    // full-memory load without HALT
    cmd(CMD_LOAD);
    check("reload_halted_clr", 32'(o_halted), 32'd0);
    check("reload_count_clr", o_cycle_count, 32'd0);
    for (int i = 0; i < 64; i++) send_word(6'(i), 32'h01000000 | 32'(i));
    check("full_done", 32'(o_done), 32'd1);
    check("full_idle", 32'(o_state), 32'd0);
    repeat (3) step();
    check("full_no_extra_we", 32'(o_inst_write_enable), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
    // ABORT coincident with the 4th byte
    cmd(CMD_LOAD);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    i_byte_valid = 1'b1;
    i_byte = 8'h44;
    i_cmd_valid = 1'b1;
    i_cmd = CMD_ABORT;
    step();
    i_byte_valid = 1'b0;
    i_cmd_valid = 1'b0;
    check("abort_state", 32'(o_state), 32'd0);
    check("abort_no_we", 32'(o_inst_write_enable), 32'd0);
    check("abort_ready", 32'(o_cmd_ready), 32'd1);
    step();
    check("abort_no_we2", 32'(o_inst_write_enable), 32'd0);
    cmd(CMD_LOAD);
    send_word(6'd0, 32'hAABBCCDD);
    check("clean_we", 32'(o_inst_write_enable), 32'd1);
    check("clean_addr", 32'(o_write_addr), 32'd0);
    check("clean_data", o_write_data, 32'hAABBCCDD);
    check("clean_still_load", 32'(o_state), 32'd1);
    cmd(CMD_ABORT);
    check("abort_load_state", 32'(o_state), 32'd0);
    // ABORT during RUN drops run enable immediately
    cmd(CMD_RUN);
    check("run2_en", 32'(o_run_en), 32'd1);
    cmd(CMD_ABORT);
    check("abort_run_en", 32'(o_run_en), 32'd0);
    check("abort_run_state", 32'(o_state), 32'd0);
    check("abort_run_halted", 32'(o_halted), 32'd0);
    step();
    check("sb_final", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
